load_store_unit: RTL and testbench

- Core-side initiator for the RV32I data memory path: takes one load/store request from the execute stage and drives a word-addressed, byte-enabled memory request/grant/response bus.
- Aligns store data to byte lanes, extracts and sign/zero-extends load data.
- Flags misaligned accesses and bus timeouts.
- Holds the core stalled via req_ready until the access completes.

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one core access, drives a word-addressed byte-enabled
// req/gnt/rvalid memory bus, aligns store lanes and extends load data.
module load_store_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_load_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_misalign_o,
    output logic              resp_buserr_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              load_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-3:0] waddr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              misalign_q;
    logic              buserr_q;

    logic              accept;
    logic              timeout_hit;
    logic              capture;
    logic [1:0]        acc_off;
    logic [3:0]        acc_be;
    logic [31:0]       acc_wdata;
    logic              acc_bad;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       ext_rdata;

    assign acc_off = req_addr_i[1:0];

    // Decode the incoming access: lane enables, replicated store data, illegal/misaligned flag.
    always_comb begin
        acc_be    = 4'b0000;
        acc_wdata = req_wdata_i;
        acc_bad   = 1'b0;
        case (req_funct3_i)
            3'b000, 3'b100: begin
                acc_be    = 4'b0001 << acc_off;
                acc_wdata = {4{req_wdata_i[7:0]}};
            end
            3'b001, 3'b101: begin
                acc_be    = 4'b0011 << acc_off;
                acc_wdata = {2{req_wdata_i[15:0]}};
                acc_bad   = acc_off[0];
            end
            3'b010: begin
                acc_be  = 4'b1111;
                acc_bad = (acc_off != 2'b00);
            end
            default: acc_bad = 1'b1;
        endcase
        if (!req_load_i && req_funct3_i[2]) begin
            acc_bad = 1'b1;
        end
    end

    always_comb begin
        byte_sel  = mem_rdata_i[{off_q, 3'b000} +: 8];
        half_sel  = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
        ext_rdata = mem_rdata_i;
        case (funct3_q)
            3'b000:  ext_rdata = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ext_rdata = {{16{half_sel[15]}}, half_sel};
            3'b100:  ext_rdata = {24'h000000, byte_sel};
            3'b101:  ext_rdata = {16'h0000, half_sel};
            default: ext_rdata = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = acc_bad ? StResp : StReq;
                end
            end
            StReq: begin
                // A grant on the final allowed cycle still completes normally.
                if (mem_gnt_i) begin
                    cnt_d   = '0;
                    state_d = load_q ? StWaitR : StResp;
                end else if (cnt_q == CntLast) begin
                    timeout_hit = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitR: begin
                if (mem_rvalid_i) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    timeout_hit = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            load_q     <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            waddr_q    <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                load_q     <= req_load_i;
                funct3_q   <= req_funct3_i;
                off_q      <= acc_off;
                waddr_q    <= req_addr_i[ADDR_W-1:2];
                be_q       <= acc_be;
                wdata_q    <= acc_wdata;
                misalign_q <= acc_bad;
                buserr_q   <= 1'b0;
                rdata_q    <= 32'h0;
            end
            if (timeout_hit) begin
                buserr_q <= 1'b1;
            end
            if (capture) begin
                rdata_q <= ext_rdata;
            end
        end
    end

    // Bus and response outputs are gated by state so idle/reset values are all zero.
    always_comb begin
        req_ready_o     = (state_q == StIdle);
        resp_valid_o    = (state_q == StResp);
        resp_rdata_o    = resp_valid_o ? rdata_q : 32'h0;
        resp_misalign_o = resp_valid_o & misalign_q;
        resp_buserr_o   = resp_valid_o & buserr_q;
        mem_req_o       = (state_q == StReq);
        mem_we_o        = mem_req_o & ~load_q;
        mem_addr_o      = mem_req_o ? waddr_q : '0;
        mem_be_o        = mem_req_o ? be_q : 4'b0000;
        mem_wdata_o     = mem_we_o ? wdata_q : 32'h0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a cycle-stepped memory responder with hand-computed
// expectations for lanes, extension, latency, faults, timeout and mid-access reset.
module tb_load_store_unit;

    localparam int unsigned TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_load_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'b000;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_misalign_o;
    logic        resp_buserr_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [29:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    load_store_unit #(
        .ADDR_W  (32),
        .TIMEOUT (TO)
    ) u_dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_load_i      (req_load_i),
        .req_funct3_i    (req_funct3_i),
        .req_addr_i      (req_addr_i),
        .req_wdata_i     (req_wdata_i),
        .resp_valid_o    (resp_valid_o),
        .resp_rdata_o    (resp_rdata_o),
        .resp_misalign_o (resp_misalign_o),
        .resp_buserr_o   (resp_buserr_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_be_o        (mem_be_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;

    int          obs_lat;
    int          obs_nreq;
    logic        obs_done;
    logic        obs_busy_ready;
    logic [29:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic        obs_we;
    logic [31:0] obs_rdata;
    logic        obs_mis;
    logic        obs_berr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // gnt_dly: REQ cycles before grant (<0 = never); rv_dly: WAIT_R cycles before rvalid.
    task automatic run(input logic load, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                       input logic [31:0] rdata);
        logic granted;
        int   wcnt;
        granted        = 1'b0;
        wcnt           = 0;
        obs_lat        = 0;
        obs_nreq       = 0;
        obs_done       = 1'b0;
        obs_busy_ready = 1'b0;
        obs_addr       = '0;
        obs_be         = '0;
        obs_wdata      = '0;
        obs_we         = 1'b0;
        obs_rdata      = '0;
        obs_mis        = 1'b0;
        obs_berr       = 1'b0;
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_load_i   = load;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        for (int c = 0; c < 100 && !obs_done; c++) begin
            @(negedge clk_i);
            obs_lat++;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (resp_valid_o) begin
                obs_rdata = resp_rdata_o;
                obs_mis   = resp_misalign_o;
                obs_berr  = resp_buserr_o;
                obs_done  = 1'b1;
            end else begin
                if (req_ready_o) obs_busy_ready = 1'b1;
                if (mem_req_o) begin
                    obs_addr  = mem_addr_o;
                    obs_be    = mem_be_o;
                    obs_wdata = mem_wdata_o;
                    obs_we    = mem_we_o;
                    if (obs_nreq == gnt_dly) begin
                        mem_gnt_i = 1'b1;
                        granted   = 1'b1;
                    end
                    obs_nreq++;
                end else if (granted && load) begin
                    if (wcnt == rv_dly) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = rdata;
                    end
                    wcnt++;
                end
            end
        end
        check("completed", {31'h0, obs_done}, 32'h1);
        check("busy_ready", {31'h0, obs_busy_ready}, 32'h0);
        @(negedge clk_i);
        check("pulse_one_cycle", {31'h0, resp_valid_o}, 32'h0);
    endtask

    initial begin
        #12;
        check("reset_ready", {31'h0, req_ready_o}, 32'h1);
        check("reset_mem_req", {31'h0, mem_req_o}, 32'h0);
        check("reset_resp", {29'h0, resp_valid_o, resp_misalign_o, resp_buserr_o}, 32'h0);
        check("reset_be", {28'h0, mem_be_o}, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // SB: byte lane 1, replicated data
        run(1'b0, 3'b000, 32'h0000_0005, 32'h1234_56AB, 0, 0, 32'h0);
        check("sb_addr", {2'b00, obs_addr}, 32'h1);
        check("sb_be", {28'h0, obs_be}, 32'h2);
        check("sb_wdata", obs_wdata, 32'hABAB_ABAB);
        check("sb_we", {31'h0, obs_we}, 32'h1);
        check("sb_lat", obs_lat, 2);
        check("sb_rdata", obs_rdata, 32'h0);
        check("sb_flags", {30'h0, obs_mis, obs_berr}, 32'h0);

        // SH upper half
        run(1'b0, 3'b001, 32'h0000_0012, 32'h0000_BEEF, 0, 0, 32'h0);
        check("sh_addr", {2'b00, obs_addr}, 32'h4);
        check("sh_be", {28'h0, obs_be}, 32'hC);
        check("sh_wdata", obs_wdata, 32'hBEEF_BEEF);

        // LB / LBU lane 3
        run(1'b1, 3'b000, 32'h0000_0003, 32'h0, 0, 0, 32'h80FF_0000);
        check("lb_rdata", obs_rdata, 32'hFFFF_FF80);
        check("lb_be", {28'h0, obs_be}, 32'h8);
        check("lb_we", {31'h0, obs_we}, 32'h0);
        check("lb_lat", obs_lat, 3);
        run(1'b1, 3'b100, 32'h0000_0003, 32'h0, 0, 0, 32'h80FF_0000);
        check("lbu_rdata", obs_rdata, 32'h0000_0080);

        // LH / LHU upper half
        run(1'b1, 3'b001, 32'h0000_0002, 32'h0, 0, 0, 32'h8001_1234);
        check("lh_rdata", obs_rdata, 32'hFFFF_8001);
        check("lh_be", {28'h0, obs_be}, 32'hC);
        run(1'b1, 3'b101, 32'h0000_0002, 32'h0, 0, 0, 32'h8001_1234);
        check("lhu_rdata", obs_rdata, 32'h0000_8001);
        run(1'b1, 3'b001, 32'h0000_0000, 32'h0, 0, 0, 32'h8001_7234);
        check("lh_low_rdata", obs_rdata, 32'h0000_7234);

        // LW, with slow grant and slow rvalid
        run(1'b1, 3'b010, 32'h0000_0004, 32'h0, 2, 3, 32'hDEAD_BEEF);
        check("lw_rdata", obs_rdata, 32'hDEAD_BEEF);
        check("lw_addr", {2'b00, obs_addr}, 32'h1);
        check("lw_be", {28'h0, obs_be}, 32'hF);
        check("lw_lat", obs_lat, 8);

        // Misaligned and illegal encodings
        run(1'b1, 3'b010, 32'h0000_0006, 32'h0, 0, 0, 32'h0);
        check("lw_mis_flag", {30'h0, obs_mis, obs_berr}, 32'h2);
        check("lw_mis_lat", obs_lat, 1);
        check("lw_mis_noreq", obs_nreq, 0);
        run(1'b0, 3'b001, 32'h0000_0001, 32'h0000_FFFF, 0, 0, 32'h0);
        check("sh_mis_flag", {30'h0, obs_mis, obs_berr}, 32'h2);
        check("sh_mis_noreq", obs_nreq, 0);
        run(1'b0, 3'b100, 32'h0000_0000, 32'h0, 0, 0, 32'h0);
        check("sbu_illegal", {30'h0, obs_mis, obs_berr}, 32'h2);
        run(1'b1, 3'b011, 32'h0000_0000, 32'h0, 0, 0, 32'h0);
        check("f3_011_illegal", {30'h0, obs_mis, obs_berr}, 32'h2);

        // Grant never arrives
        run(1'b0, 3'b010, 32'h0000_0010, 32'h1111_2222, -1, 0, 32'h0);
        check("to_gnt_flags", {30'h0, obs_mis, obs_berr}, 32'h1);
        check("to_gnt_nreq", obs_nreq, TO);
        check("to_gnt_lat", obs_lat, TO + 1);
        // Grant on the last allowed cycle wins
        run(1'b0, 3'b010, 32'h0000_0010, 32'h1111_2222, TO - 1, 0, 32'h0);
        check("late_gnt_flags", {30'h0, obs_mis, obs_berr}, 32'h0);
        check("late_gnt_lat", obs_lat, TO + 1);
        // rvalid never arrives
        run(1'b1, 3'b010, 32'h0000_0010, 32'h0, 0, 1000, 32'h5555_5555);
        check("to_rv_flags", {30'h0, obs_mis, obs_berr}, 32'h1);
        check("to_rv_rdata", obs_rdata, 32'h0);
        check("to_rv_lat", obs_lat, TO + 2);

        // Reset while waiting for read data
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_load_i   = 1'b1;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h0000_0008;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        check("rst_seq_req", {31'h0, mem_req_o}, 32'h1);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        check("rst_seq_waitr", {30'h0, mem_req_o, req_ready_o}, 32'h0);
        rst_ni = 1'b0;
        #1;
        check("rst_mid_ready", {31'h0, req_ready_o}, 32'h1);
        check("rst_mid_resp", {31'h0, resp_valid_o}, 32'h0);
        @(negedge clk_i);
        rst_ni       = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        check("late_rv_ignored", {31'h0, resp_valid_o}, 32'h0);
        check("late_rv_ready", {31'h0, req_ready_o}, 32'h1);
        @(negedge clk_i);
        check("late_rv_ignored2", {31'h0, resp_valid_o}, 32'h0);
        run(1'b1, 3'b010, 32'h0000_0008, 32'h0, 0, 0, 32'hCAFE_F00D);
        check("post_rst_rdata", obs_rdata, 32'hCAFE_F00D);
        check("post_rst_lat", obs_lat, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
